// File: rtl/set_row_sequencer_if.sv
// Command and issue bus between the SET command source and the row sequencer.
// The master drives commands; the slave (sequencer) drives status and row issues.
interface set_row_sequencer_if;
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic        busy;
    logic        valid;
    logic        start;
    logic        cand_en;
    logic [2:0]  now_id;
    logic [1:0]  count;
    logic [11:0] circle_data;
    logic [1:0]  reg_mode;
    logic        row_last;

    modport master (
        output en, central, radius, mode,
        input  busy, valid, start, cand_en, now_id, count, circle_data, reg_mode, row_last
    );

    modport slave (
        input  en, central, radius, mode,
        output busy, valid, start, cand_en, now_id, count, circle_data, reg_mode, row_last
    );
endinterface

// File: rtl/set_row_sequencer.sv
// Row-major command sequencer for the SET point counter: one pass per circle per grid row.
// Optional SET_ROW_SKIP_EN skips rows that no participating circle can reach.
module set_row_sequencer #(
    parameter int ROWS    = 8,
    parameter int ADD_LAT = 1
) (
    input logic clk,
    input logic rst,
    set_row_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((ADD_LAT > 0) ? ADD_LAT - 1 : 0);

    state_t state, state_nxt;

    logic [23:0]     central_q;
    logic [11:0]     radius_q;
    logic [1:0]      mode_q;
    logic [2:0]      row_cur;
    logic [1:0]      pass_cur;
    logic [2:0]      row_hold;
    logic [1:0]      pass_hold;
    logic [11:0]     data_hold;
    logic [DW-1:0]   drain_cnt;

    logic [1:0]      pass_last;
    logic [11:0]     cur_data;
    logic [ROWS-1:0] row_ok;
    logic [2:0]      first_row;
    logic            first_found;
    logic [2:0]      next_row;
    logic            next_found;

    assign pass_last = (mode_q == 2'd0) ? 2'd0 : ((mode_q == 2'd3) ? 2'd2 : 2'd1);

    always_comb begin
        cur_data = '0;
        case (pass_cur)
            2'd0:    cur_data = {central_q[23:16], radius_q[11:8]};
            2'd1:    cur_data = {central_q[15:8],  radius_q[7:4]};
            default: cur_data = {central_q[7:0],   radius_q[3:0]};
        endcase
    end

`ifdef SET_ROW_SKIP_EN
    // Vertical reach test on 5-bit signed differences; grid y is row index + 1.
    function automatic logic circle_hits(input logic [3:0] y, input logic [3:0] r, input logic [3:0] gy);
        logic signed [4:0] diff;
        logic [4:0]        mag;
        diff = $signed({1'b0, y}) - $signed({1'b0, gy});
        mag  = (diff < 0) ? 5'(-diff) : 5'(diff);
        return (mag <= {1'b0, r});
    endfunction

    always_comb begin
        row_ok = '0;
        for (int i = 0; i < ROWS; i++) begin
            row_ok[i] = circle_hits(central_q[19:16], radius_q[11:8], 4'(i + 1))
                     || ((mode_q != 2'd0) && circle_hits(central_q[11:8], radius_q[7:4], 4'(i + 1)))
                     || ((mode_q == 2'd3) && circle_hits(central_q[3:0], radius_q[3:0], 4'(i + 1)));
        end
    end
`else
    assign row_ok = '1;
`endif

    // Lowest qualifying row overall, and lowest qualifying row above the cursor.
    always_comb begin
        first_row   = '0;
        first_found = 1'b0;
        next_row    = '0;
        next_found  = 1'b0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (row_ok[i]) begin
                first_row   = 3'(i);
                first_found = 1'b1;
                if (i > int'(row_cur)) begin
                    next_row   = 3'(i);
                    next_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.en) state_nxt = LOAD;
            LOAD: begin
                if (first_found)       state_nxt = ISSUE;
                else if (ADD_LAT == 0) state_nxt = DONE;
                else                   state_nxt = DRAIN;
            end
            ISSUE: begin
                if (pass_cur == pass_last && !next_found)
                    state_nxt = (ADD_LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
            row_cur   <= '0;
            pass_cur  <= '0;
            row_hold  <= '0;
            pass_hold <= '0;
            data_hold <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        central_q <= bus.central;
                        radius_q  <= bus.radius;
                        mode_q    <= bus.mode;
                    end
                end
                LOAD: begin
                    row_cur   <= first_row;
                    pass_cur  <= '0;
                    drain_cnt <= '0;
                end
                ISSUE: begin
                    row_hold  <= row_cur;
                    pass_hold <= pass_cur;
                    data_hold <= cur_data;
                    drain_cnt <= '0;
                    // The final row keeps its cursor; the next LOAD re-seeds it.
                    if (pass_cur == pass_last) begin
                        pass_cur <= '0;
                        if (next_found) row_cur <= next_row;
                    end else begin
                        pass_cur <= pass_cur + 2'd1;
                    end
                end
                DRAIN: drain_cnt <= drain_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy        = (state != IDLE);
        bus.start       = (state == LOAD);
        bus.valid       = (state == DONE);
        bus.cand_en     = (state == ISSUE);
        bus.now_id      = row_hold;
        bus.count       = pass_hold;
        bus.circle_data = data_hold;
        bus.row_last    = 1'b0;
        bus.reg_mode    = mode_q;
        if (state == ISSUE) begin
            bus.now_id      = row_cur;
            bus.count       = pass_cur;
            bus.circle_data = cur_data;
            bus.row_last    = (pass_cur == pass_last);
        end
    end

endmodule

// File: tb/tb_set_row_sequencer.sv
// Directed bench for set_row_sequencer: ADD_LAT=1 and ADD_LAT=0 instances, cycle-exact checks.
// Row masks follow SET_ROW_SKIP_EN so the same vectors serve both builds.
module tb_set_row_sequencer;

`ifdef SET_ROW_SKIP_EN
    localparam logic [7:0] MASK_M0    = 8'h3E;
    localparam logic [7:0] MASK_SKIP1 = 8'h0F;
    localparam logic [7:0] MASK_SKIP0 = 8'h00;
`else
    localparam logic [7:0] MASK_M0    = 8'hFF;
    localparam logic [7:0] MASK_SKIP1 = 8'hFF;
    localparam logic [7:0] MASK_SKIP0 = 8'hFF;
`endif

    logic        clk;
    logic        rst;
    logic        en_drv;
    logic [23:0] central_drv;
    logic [11:0] radius_drv;
    logic [1:0]  mode_drv;
    logic        sel_z;

    int tests_run;
    int tests_failed;

    set_row_sequencer_if bus_a ();
    set_row_sequencer_if bus_z ();

    assign bus_a.en      = en_drv && !sel_z;
    assign bus_z.en      = en_drv && sel_z;
    assign bus_a.central = central_drv;
    assign bus_z.central = central_drv;
    assign bus_a.radius  = radius_drv;
    assign bus_z.radius  = radius_drv;
    assign bus_a.mode    = mode_drv;
    assign bus_z.mode    = mode_drv;

    set_row_sequencer #(.ROWS(8), .ADD_LAT(1)) dut (.clk(clk), .rst(rst), .bus(bus_a));
    set_row_sequencer #(.ROWS(8), .ADD_LAT(0)) dut_z (.clk(clk), .rst(rst), .bus(bus_z));

    logic        busy_o, valid_o, start_o, cand_o, last_o;
    logic [2:0]  id_o;
    logic [1:0]  cnt_o, rmode_o;
    logic [11:0] data_o;

    assign busy_o  = sel_z ? bus_z.busy        : bus_a.busy;
    assign valid_o = sel_z ? bus_z.valid       : bus_a.valid;
    assign start_o = sel_z ? bus_z.start       : bus_a.start;
    assign cand_o  = sel_z ? bus_z.cand_en     : bus_a.cand_en;
    assign last_o  = sel_z ? bus_z.row_last    : bus_a.row_last;
    assign id_o    = sel_z ? bus_z.now_id      : bus_a.now_id;
    assign cnt_o   = sel_z ? bus_z.count       : bus_a.count;
    assign rmode_o = sel_z ? bus_z.reg_mode    : bus_a.reg_mode;
    assign data_o  = sel_z ? bus_z.circle_data : bus_a.circle_data;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".busy"},  32'(busy_o),  32'd0);
        checkOutput({tag, ".valid"}, 32'(valid_o), 32'd0);
        checkOutput({tag, ".start"}, 32'(start_o), 32'd0);
        checkOutput({tag, ".cand"},  32'(cand_o),  32'd0);
        checkOutput({tag, ".last"},  32'(last_o),  32'd0);
        checkOutput({tag, ".id"},    32'(id_o),    32'd0);
        checkOutput({tag, ".cnt"},   32'(cnt_o),   32'd0);
        checkOutput({tag, ".mode"},  32'(rmode_o), 32'd0);
        checkOutput({tag, ".data"},  32'(data_o),  32'd0);
    endtask

    // One command from IDLE; inject_idx pulses a stray en, abort_idx resets mid-issue (-1 = off).
    task automatic applyStimulus(input string tag, input logic [23:0] c, input logic [11:0] r,
                                 input logic [1:0] m, input logic [7:0] mask,
                                 input int inject_idx, input int abort_idx);
        int          npass, lat, idx;
        logic        injected;
        logic [2:0]  last_row;
        logic [1:0]  last_pass;
        logic [11:0] last_data;
        npass    = (m == 2'd0) ? 1 : ((m == 2'd3) ? 3 : 2);
        lat      = sel_z ? 0 : 1;
        idx      = 0;
        injected = 1'b0;
        last_row = '0; last_pass = '0; last_data = '0;

        central_drv = c; radius_drv = r; mode_drv = m; en_drv = 1'b1;
        tick();
        en_drv = 1'b0;
        checkOutput({tag, ".load.start"}, 32'(start_o), 32'd1);
        checkOutput({tag, ".load.busy"},  32'(busy_o),  32'd1);
        checkOutput({tag, ".load.cand"},  32'(cand_o),  32'd0);
        checkOutput({tag, ".load.valid"}, 32'(valid_o), 32'd0);
        checkOutput({tag, ".load.mode"},  32'(rmode_o), 32'(m));

        for (int row = 0; row < 8; row++) begin
            if (mask[row]) begin
                for (int p = 0; p < npass; p++) begin
                    tick();
                    if (injected) begin
                        en_drv = 1'b0; central_drv = c; mode_drv = m; injected = 1'b0;
                    end
                    last_row  = 3'(row);
                    last_pass = 2'(p);
                    last_data = {c[23 - 8*p -: 8], r[11 - 4*p -: 4]};
                    checkOutput({tag, ".iss.cand"},  32'(cand_o),  32'd1);
                    checkOutput({tag, ".iss.busy"},  32'(busy_o),  32'd1);
                    checkOutput({tag, ".iss.start"}, 32'(start_o), 32'd0);
                    checkOutput({tag, ".iss.valid"}, 32'(valid_o), 32'd0);
                    checkOutput({tag, ".iss.id"},    32'(id_o),    32'(row));
                    checkOutput({tag, ".iss.cnt"},   32'(cnt_o),   32'(p));
                    checkOutput({tag, ".iss.data"},  32'(data_o),  32'(last_data));
                    checkOutput({tag, ".iss.last"},  32'(last_o),  32'(p == npass - 1));
                    checkOutput({tag, ".iss.mode"},  32'(rmode_o), 32'(m));
                    if (idx == abort_idx) begin
                        rst = 1'b0;
                        tick();
                        rst = 1'b1;
                        checkAllZero({tag, ".abort"});
                        for (int k = 0; k < 14; k++) begin
                            tick();
                            checkOutput({tag, ".abort.valid"}, 32'(valid_o), 32'd0);
                            checkOutput({tag, ".abort.busy"},  32'(busy_o),  32'd0);
                        end
                        return;
                    end
                    if (idx == inject_idx) begin
                        en_drv = 1'b1; central_drv = 24'hFFFFFF; mode_drv = 2'd3; injected = 1'b1;
                    end
                    idx++;
                end
            end
        end

        for (int d = 0; d < lat; d++) begin
            tick();
            checkOutput({tag, ".drain.cand"},  32'(cand_o),  32'd0);
            checkOutput({tag, ".drain.busy"},  32'(busy_o),  32'd1);
            checkOutput({tag, ".drain.valid"}, 32'(valid_o), 32'd0);
            if (mask != 8'h00) begin
                checkOutput({tag, ".drain.id"},   32'(id_o),   32'(last_row));
                checkOutput({tag, ".drain.cnt"},  32'(cnt_o),  32'(last_pass));
                checkOutput({tag, ".drain.data"}, 32'(data_o), 32'(last_data));
            end
        end

        tick();
        checkOutput({tag, ".done.valid"}, 32'(valid_o), 32'd1);
        checkOutput({tag, ".done.busy"},  32'(busy_o),  32'd1);
        checkOutput({tag, ".done.cand"},  32'(cand_o),  32'd0);
        checkOutput({tag, ".done.start"}, 32'(start_o), 32'd0);

        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput({tag, ".idle.busy"},  32'(busy_o),  32'd0);
            checkOutput({tag, ".idle.valid"}, 32'(valid_o), 32'd0);
            checkOutput({tag, ".idle.mode"},  32'(rmode_o), 32'(m));
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; en_drv = 1'b0;
        central_drv = '0; radius_drv = '0; mode_drv = '0; sel_z = 1'b0;
        tests_run = 0; tests_failed = 0;

        tick();
        tick();
        checkAllZero("reset.a");
        sel_z = 1'b1;
        checkAllZero("reset.z");
        sel_z = 1'b0;
        rst = 1'b1;
        tick();

        applyStimulus("m0",     24'h440000, 12'h200, 2'd0, MASK_M0, -1, -1);
        applyStimulus("m3",     24'h335577, 12'h222, 2'd3, 8'hFF,   -1, -1);
        applyStimulus("inject", 24'h335500, 12'h770, 2'd1, 8'hFF,    2, -1);
        applyStimulus("abort",  24'h335577, 12'h222, 2'd3, 8'hFF,   -1,  4);
        applyStimulus("post",   24'h440000, 12'h200, 2'd0, MASK_M0, -1, -1);

        sel_z = 1'b1;
        applyStimulus("lat0",   24'h123456, 12'h880, 2'd2, 8'hFF,   -1, -1);
        sel_z = 1'b0;

        applyStimulus("skip1",  24'h425300, 12'h110, 2'd1, MASK_SKIP1, -1, -1);
        applyStimulus("skip0",  24'h4F0000, 12'h200, 2'd0, MASK_SKIP0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
